// File: rtl/nixie_display_arbiter.sv
// Round-robin arbiter sharing one 8-digit display among four requesters.
// A grant is held for a minimum dwell, then rotates if anyone else is waiting.
module nixie_display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter logic [31:0] IDLE_VALUE  = 32'h0000_0000
) (
  input  logic         CLOCK_50,
  input  logic         RESET,
  input  logic [3:0]   req,
  input  logic [127:0] req_data,
  output logic [31:0]  num,
  output logic [3:0]   grant,
  output logic [1:0]   active_id,
  output logic         switch_pulse
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  localparam logic [25:0] RELOAD = 26'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [25:0] timer_q, timer_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  id_q, id_d;
  logic [3:0]  grant_q, grant_d;
  logic [31:0] num_q, num_d;
  logic        pulse_q, pulse_d;

  logic [3:0]  cand;
  logic [1:0]  idx;
  logic [1:0]  win_id;
  logic        win_found;
  logic        take_win;
  logic        go_idle;
  logic        reload;

  // Current holder is masked out so rotation always moves on.
  always_comb begin
    cand      = req & ~grant_q;
    idx       = '0;
    win_id    = last_q;
    win_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  always_comb begin
    take_win = 1'b0;
    go_idle  = 1'b0;
    reload   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) take_win = 1'b1;
      end
      HOLD: begin
        if (!req[id_q]) begin
          if (win_found) take_win = 1'b1;
          else           go_idle  = 1'b1;
        end else if (timer_q == '0) begin
          if (win_found) take_win = 1'b1;
          else           reload   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    grant_d = grant_q;
    pulse_d = 1'b0;
    timer_d = (timer_q != '0) ? timer_q - 26'd1 : '0;
    num_d   = (state_q == HOLD) ? req_data[{id_q, 5'b0} +: 32]
                                : IDLE_VALUE;
    if (take_win) begin
      state_d = HOLD;
      last_d  = win_id;
      id_d    = win_id;
      grant_d = 4'b0001 << win_id;
      timer_d = RELOAD;
      pulse_d = 1'b1;
      num_d   = req_data[{win_id, 5'b0} +: 32];
    end else if (go_idle) begin
      state_d = IDLE;
      id_d    = '0;
      grant_d = '0;
      timer_d = '0;
      pulse_d = 1'b1;
      num_d   = IDLE_VALUE;
    end else if (reload) begin
      timer_d = RELOAD;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      timer_q <= '0;
      last_q  <= 2'd3;
      id_q    <= '0;
      grant_q <= '0;
      num_q   <= IDLE_VALUE;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      last_q  <= last_d;
      id_q    <= id_d;
      grant_q <= grant_d;
      num_q   <= num_d;
      pulse_q <= pulse_d;
    end
  end

  assign num          = num_q;
  assign grant        = grant_q;
  assign active_id    = id_q;
  assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_nixie_display_arbiter.sv
// Bench for nixie_display_arbiter: owner/dwell model plus
// directed scenarios with literal expectations.
module tb_nixie_display_arbiter;

  localparam int          HOLD  = 4;
  localparam logic [31:0] IDLEV = 32'hE0E0_E0E0;

  logic         CLOCK_50 = 1'b0;
  logic         RESET;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [31:0]  num;
  logic [3:0]   grant;
  logic [1:0]   active_id;
  logic         switch_pulse;

  always #5 CLOCK_50 = ~CLOCK_50;

  nixie_display_arbiter #(
    .HOLD_CYCLES(HOLD),
    .IDLE_VALUE (IDLEV)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET       (RESET),
    .req         (req),
    .req_data    (req_data),
    .num         (num),
    .grant       (grant),
    .active_id   (active_id),
    .switch_pulse(switch_pulse)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Model: owner (-1 = idle), dwell = cycles shown so far, ptr = last winner.
  int          own;
  int          dwell;
  int          ptr;
  logic        m_pulse;
  logic [31:0] m_num;

  always @(posedge CLOCK_50 or negedge RESET) begin : model
    int n;
    int c;
    bit expired;
    if (!RESET) begin
      own     <= -1;
      ptr     <= 3;
      dwell   <= 0;
      m_pulse <= 1'b0;
      m_num   <= IDLEV;
    end else begin
      n = own;
      expired = (own >= 0) && req[own] && (dwell >= HOLD);
      if (own < 0 || !req[own] || expired) begin
        n = -1;
        for (int k = 1; k <= 4; k++) begin
          c = (ptr + k) % 4;
          if (n < 0 && req[c] && c != own) n = c;
        end
        if (n < 0 && expired) n = own;
      end
      m_pulse <= (n != own);
      if (n >= 0) ptr <= n;
      own   <= n;
      dwell <= (n != own || expired) ? 1 : ((n < 0) ? 0 : dwell + 1);
      m_num <= (n < 0) ? IDLEV : req_data[n*32 +: 32];
    end
  end

  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      chk("m_num", num, m_num);
      chk("m_grant", {28'd0, grant},
          (own < 0) ? 32'd0 : (32'd1 << own));
      chk("m_id", {30'd0, active_id}, (own < 0) ? 32'd0 : 32'(own));
      chk("m_pulse", {31'd0, switch_pulse}, {31'd0, m_pulse});
    end
  end

  int ids [13];
  int exp_ids [13] = '{0, 0, 0, 0, 1, 1, 1, 1, 3, 3, 3, 3, 0};
  int npulse;

  initial begin
    RESET    = 1'b0;
    req      = 4'b0000;
    req_data = {32'h3333_0003, 32'h2222_0002,
                32'h1234_5678, 32'h0000_1000};
    step(2);
    RESET  = 1'b1;
    chk_en = 1'b1;

    // idle after reset
    step(10);
    chk("t1_num", num, IDLEV);
    chk("t1_grant", {28'd0, grant}, 32'd0);
    chk("t1_pulse", {31'd0, switch_pulse}, 32'd0);

    // single requester, live data tracking
    req = 4'b0010;
    step(1);
    chk("t2_grant", {28'd0, grant}, 32'h2);
    chk("t2_id", {30'd0, active_id}, 32'd1);
    chk("t2_num", num, 32'h1234_5678);
    chk("t2_pulse", {31'd0, switch_pulse}, 32'd1);
    req_data[63:32] = 32'h0000_0099;
    step(1);
    chk("t2_live", num, 32'h0000_0099);
    chk("t2_pulse2", {31'd0, switch_pulse}, 32'd0);
    req = 4'b0000;
    step(1);
    chk("t2_idle", {28'd0, grant}, 32'd0);
    chk("t2_idlep", {31'd0, switch_pulse}, 32'd1);
    step(2);

    // steady 1011 from fresh reset: 0,1,3,0 with 4-cycle dwell
    RESET = 1'b0;
    step(1);
    RESET = 1'b1;
    req = 4'b1011;
    npulse = 0;
    for (int i = 0; i < 13; i++) begin
      step(1);
      ids[i] = active_id;
      npulse += switch_pulse;
    end
    for (int i = 0; i < 13; i++)
      chk($sformatf("t3_seq%0d", i), 32'(ids[i]), 32'(exp_ids[i]));
    chk("t3_npulse", 32'(npulse), 32'd4);
    req = 4'b0000;
    step(2);

    // no preemption before dwell expiry
    req = 4'b0001;
    step(1);
    chk("t4_c1", {28'd0, grant}, 32'h1);
    req = 4'b0101;
    step(1);
    chk("t4_c2", {28'd0, grant}, 32'h1);
    step(1);
    chk("t4_c3", {28'd0, grant}, 32'h1);
    step(1);
    chk("t4_c4", {28'd0, grant}, 32'h1);
    step(1);
    chk("t4_rot", {28'd0, grant}, 32'h4);
    chk("t4_pulse", {31'd0, switch_pulse}, 32'd1);

    // holder drops early, nobody else
    req = 4'b0000;
    step(1);
    chk("t5_grant", {28'd0, grant}, 32'd0);
    chk("t5_num", num, IDLEV);
    chk("t5_pulse", {31'd0, switch_pulse}, 32'd1);
    step(2);

    // async reset mid-grant
    req = 4'b1000;
    step(2);
    chk("t6_pre", {28'd0, grant}, 32'h8);
    #2 RESET = 1'b0;
    #1;
    chk("t6_grant", {28'd0, grant}, 32'd0);
    chk("t6_num", num, IDLEV);
    chk("t6_id", {30'd0, active_id}, 32'd0);
    chk("t6_pulse", {31'd0, switch_pulse}, 32'd0);
    req = 4'b1001;
    step(1);
    RESET = 1'b1;
    step(1);
    chk("t6_first", {28'd0, grant}, 32'h1);

    // holder 3 drops while 1 and 2 arrive: RR from 3 picks 1
    step(4);
    chk("t7_hold3", {28'd0, grant}, 32'h8);
    req = 4'b0110;
    step(1);
    chk("t7_pick", {28'd0, grant}, 32'h2);
    chk("t7_num", num, 32'h0000_0099);
    req = 4'b0000;
    step(3);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nixie_display_arbiter.md
Name: nixie_display_arbiter

Overview:
- Shares the single 8-digit seven-segment display between four requesters, e.g. counter, clock, debug register and error code.
- Each requester supplies a 32-bit value. The arbiter grants the display round-robin with a guaranteed minimum dwell time per grant.
- Drives the 32-bit value bus of the display datapath. Sits directly upstream of the digit split, segment decode and scan logic.

Parameters:
- HOLD_CYCLES, 50_000_000, minimum dwell of a grant in clock cycles (1 s at 50 MHz); legal range 1..2^26-1.
- IDLE_VALUE, 32'h0000_0000, value shown when no requester is active.

Ports:
- CLOCK_50  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- req  in  4  per-requester display request; bit i belongs to requester i.
- req_data  in  128  requester values, flattened; requester i occupies [32*i+31:32*i].
- num  out  32  value driven to the display datapath.
- grant  out  4  one-hot grant, or all zero when idle.
- active_id  out  2  index of the granted requester; 0 when idle.
- switch_pulse  out  1  one-cycle pulse whenever the display source changes, including to and from idle.

Behaviour:
- Reset values (RESET low, asynchronous): num=IDLE_VALUE, grant=0, active_id=0, switch_pulse=0, state=IDLE, timer=0, last_id=3, so the first round-robin pick is requester 0.
- All outputs are registered. Latency from req rising to grant/num valid is 1 cycle.
- Round-robin pick:
  - Search indices last_id+1, last_id+2, ... mod 4.
  - The first index with req=1 wins.
  - last_id updates to the winner on every grant.
- State IDLE:
  - num=IDLE_VALUE, grant=0.
  - If req!=0: grant the RR winner, num<=winner's data, timer<=HOLD_CYCLES-1, switch_pulse=1, go to HOLD.
- State HOLD, every cycle:
  - num tracks the granted requester's data live, no freezing.
  - timer decrements, saturating at 0.
- HOLD, granted req drops (at any time, including before dwell expiry):
  - If any other req is set: next cycle grant the RR winner among them, reload timer, switch_pulse=1.
  - Otherwise: go to IDLE, num=IDLE_VALUE, grant=0, switch_pulse=1.
- HOLD, timer==0 and granted req still high:
  - If another req is set: rotate to the RR winner (the current holder is excluded by the RR order), reload timer, switch_pulse=1.
  - If no other req is set: keep the grant, reload timer, switch_pulse=0.
- Other requesters never preempt before the timer reaches 0.
- Simultaneous events:
  - A new request arriving in the same cycle the holder drops is eligible in that cycle's pick.
  - Multiple new requests are resolved purely by RR order.
- HOLD_CYCLES=1: a rotation check happens every cycle, giving round-robin per clock when several requesters are active.
- Reset mid-grant returns to the reset values immediately. The RR pointer restarts at requester 0.
- grant is always one-hot or zero. active_id always equals the index of the set grant bit.
- switch_pulse is never high for two consecutive cycles when the source is unchanged.

Test Plan:
1. Reset release, req=4'b0000 for 10 cycles -> num=IDLE_VALUE, grant=0, switch_pulse never asserted.
2. HOLD_CYCLES=4; req=4'b0010 with data1=32'h1234_5678 -> 1 cycle later grant=4'b0010, active_id=1, num=32'h1234_5678, one switch_pulse. Changing data1 to 32'h0000_0099 updates num on the next cycle.
3. HOLD_CYCLES=4; req=4'b1011 held steady -> grant sequence 0,1,3,0,... Each grant lasts exactly 4 cycles, with one switch_pulse per change.
4. HOLD_CYCLES=4; requester 0 granted, req2 asserted at grant cycle 1 -> no switch before cycle 4; grant=4'b0100 at cycle 4.
5. Requester 2 granted, req2 drops at cycle 1 with req=0 otherwise -> next cycle grant=0, num=IDLE_VALUE, switch_pulse=1.
6. RESET low mid-HOLD (grant=4'b1000) -> outputs return to reset values asynchronously. After release with req=4'b1001, requester 0 is granted first.
